// File: rtl/gravity_timer.sv
// gravity_timer
// Turns the divided game tick into gravity for the falling piece. Rising
// edges of tick_in are counted at a level-dependent rate. Each terminal
// count raises a one-row drop request that is held until drop_ack. A landed
// acknowledge starts a lock-delay countdown, which ends in a single
// lock_pulse per piece.
//
// Optional feature: define GRAVITY_SOFTDROP_EN to let soft_drop force a
// one-tick drop period. Without it, soft_drop is accepted but ignored.
//
// state | meaning
// IDLE  | no piece in play, counter held at zero
// FALL  | counting tick events toward the next drop
// REQ   | drop request raised, waiting for drop_ack
// LOCK  | piece has landed, counting the lock delay
// DONE  | lock pulse issued, waiting for piece_active to fall

module gravity_timer #(
    parameter int LEVEL_W     = 4,
    parameter int CNT_W       = 5,
    parameter int BASE_PERIOD = 8,
    parameter int MIN_PERIOD  = 1,
    parameter int LOCK_TICKS  = 4
) (
    input  logic               CLK_50M,
    input  logic               rst,
    input  logic               tick_in,
    input  logic [LEVEL_W-1:0] level,
    input  logic               soft_drop,
    input  logic               piece_active,
    input  logic               drop_ack,
    input  logic               landed,
    output logic               drop_req,
    output logic               lock_pulse,
    output logic [2:0]         state_dbg
);

    localparam int PW = CNT_W + 1;
    localparam logic [31:0] CLAMP_LVL = 32'(BASE_PERIOD - MIN_PERIOD);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FALL = 3'd1,
        REQ  = 3'd2,
        LOCK = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tick_q;
    logic             tick_evt;
    logic             lock_q;
    logic             lock_nxt;
    logic [PW-1:0]    period;
    logic [PW-1:0]    cnt_inc;
    logic [31:0]      level_w;

    assign tick_evt = tick_in & ~tick_q;
    assign cnt_inc  = {1'b0, cnt} + PW'(1);
    assign level_w  = 32'(level);

`ifndef GRAVITY_SOFTDROP_EN
    logic unused_soft_drop;
    assign unused_soft_drop = soft_drop;
`endif

    // Drop period from level, clamped at the floor; comparison is done wide so nothing wraps
    always_comb begin
        if (level_w >= CLAMP_LVL)
            period = PW'(MIN_PERIOD);
        else
            period = PW'(32'(BASE_PERIOD) - level_w);
`ifdef GRAVITY_SOFTDROP_EN
        if (soft_drop)
            period = PW'(1);
`endif
    end

    // State, counter, tick edge history and lock flag registers
    always_ff @(posedge CLK_50M) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            tick_q <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            tick_q <= tick_in;
            lock_q <= lock_nxt;
        end
    end

    // Next-state and counter update; losing the piece overrides everything but reset
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lock_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (piece_active)
                    state_nxt = FALL;
            end
            FALL: begin
                if (!piece_active) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (tick_evt) begin
                    // >= so that a shorter period from a level change applies at once
                    if (cnt_inc >= period) begin
                        state_nxt = REQ;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            REQ: begin
                if (!piece_active) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (drop_ack) begin
                    state_nxt = landed ? LOCK : FALL;
                    cnt_nxt   = '0;
                end
            end
            LOCK: begin
                if (!piece_active) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (tick_evt) begin
                    if (cnt_inc == PW'(LOCK_TICKS)) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                        lock_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            DONE: begin
                cnt_nxt = '0;
                if (!piece_active)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state and the registered lock flag
    always_comb begin
        drop_req   = (state == REQ);
        lock_pulse = lock_q;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_gravity_timer.sv
// tb_gravity_timer
// Randomised stimulus against a behavioural model of gravity, drop handshake
// and lock delay. The model pushes expected per-cycle state/request levels
// and expected edge events (R = request rises, F = request falls, L = lock
// pulse) into queues; a negedge monitor pops and compares them.
// Honours GRAVITY_SOFTDROP_EN in the same way as the design.

module tb_gravity_timer;

    localparam int LEVEL_W     = 4;
    localparam int CNT_W       = 5;
    localparam int BASE_PERIOD = 8;
    localparam int MIN_PERIOD  = 1;
    localparam int LOCK_TICKS  = 4;

    localparam int M_IDLE = 0;
    localparam int M_FALL = 1;
    localparam int M_REQ  = 2;
    localparam int M_LOCK = 3;
    localparam int M_DONE = 4;

    logic               CLK_50M = 1'b0;
    logic               rst = 1'b1;
    logic               tick_in = 1'b0;
    logic [LEVEL_W-1:0] level = '0;
    logic               soft_drop = 1'b0;
    logic               piece_active = 1'b0;
    logic               drop_ack = 1'b0;
    logic               landed = 1'b0;
    logic               drop_req;
    logic               lock_pulse;
    logic [2:0]         state_dbg;

    always #5 CLK_50M = ~CLK_50M;

    gravity_timer #(
        .LEVEL_W    (LEVEL_W),
        .CNT_W      (CNT_W),
        .BASE_PERIOD(BASE_PERIOD),
        .MIN_PERIOD (MIN_PERIOD),
        .LOCK_TICKS (LOCK_TICKS)
    ) dut (
        .CLK_50M     (CLK_50M),
        .rst         (rst),
        .tick_in     (tick_in),
        .level       (level),
        .soft_drop   (soft_drop),
        .piece_active(piece_active),
        .drop_ack    (drop_ack),
        .landed      (landed),
        .drop_req    (drop_req),
        .lock_pulse  (lock_pulse),
        .state_dbg   (state_dbg)
    );

    int cyc = 0;
    always @(posedge CLK_50M) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] kind;
        int         at;
    } ev_t;

    typedef struct {
        int   st;
        logic req;
        int   at;
    } st_t;

    ev_t evq[$];
    st_t stq[$];

    int   tests = 0;
    int   fails = 0;
    int   to_cnt = 0;
    bit   mon_on = 0;
    bit   fin_req = 0;
    bit   fin_done = 0;
    logic prev_req = 1'b0;

    // ---------------- behavioural model ----------------
    int m_ph = M_IDLE;
    int m_ticks = 0;
    bit m_prev = 0;

    function automatic int exp_period();
        int p;
        p = BASE_PERIOD - int'(level);
        if (p < MIN_PERIOD) p = MIN_PERIOD;
`ifdef GRAVITY_SOFTDROP_EN
        if (soft_drop) p = 1;
`endif
        return p;
    endfunction

    task automatic push_ev(input logic [7:0] k);
        ev_t e;
        e.kind = k;
        e.at   = cyc + 1;
        evq.push_back(e);
    endtask

    // Predicts what the DUT shows after the coming edge, from the inputs now applied
    task automatic model_step();
        bit  tev;
        int  per;
        st_t s;
        tev = tick_in && !m_prev;
        if (rst) begin
            if (m_ph == M_REQ) push_ev("F");
            m_ph = M_IDLE;
            m_ticks = 0;
            m_prev = 0;
        end else begin
            m_prev = tick_in;
            per = exp_period();
            case (m_ph)
                M_IDLE: begin
                    m_ticks = 0;
                    if (piece_active) m_ph = M_FALL;
                end
                M_FALL: begin
                    if (!piece_active) begin
                        m_ph = M_IDLE; m_ticks = 0;
                    end else if (tev) begin
                        m_ticks++;
                        if (m_ticks >= per) begin
                            push_ev("R"); m_ph = M_REQ; m_ticks = 0;
                        end
                    end
                end
                M_REQ: begin
                    if (!piece_active) begin
                        push_ev("F"); m_ph = M_IDLE; m_ticks = 0;
                    end else if (drop_ack) begin
                        push_ev("F"); m_ticks = 0;
                        m_ph = landed ? M_LOCK : M_FALL;
                    end
                end
                M_LOCK: begin
                    if (!piece_active) begin
                        m_ph = M_IDLE; m_ticks = 0;
                    end else if (tev) begin
                        m_ticks++;
                        if (m_ticks == LOCK_TICKS) begin
                            push_ev("L"); m_ph = M_DONE; m_ticks = 0;
                        end
                    end
                end
                default: begin
                    if (!piece_active) m_ph = M_IDLE;
                end
            endcase
        end
        s.st  = m_ph;
        s.req = (m_ph == M_REQ);
        s.at  = cyc + 1;
        stq.push_back(s);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check_ev(input logic [7:0] k);
        ev_t e;
        tests++;
        if (evq.size() == 0) begin
            fails++;
            $display("FAIL ev_extra: got %s@%0d, expected none", k, cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != k || e.at != cyc) begin
                fails++;
                $display("FAIL ev_order: got %s@%0d, expected %s@%0d", k, cyc, e.kind, e.at);
            end
        end
    endtask

    // Compare per-cycle state and every output edge against the model's queues
    always @(negedge CLK_50M) begin
        st_t s;
        if (mon_on) begin
            tests++;
            if (stq.size() == 0) begin
                fails++;
                $display("FAIL state_q: got state %0d@%0d, expected no entry", state_dbg, cyc);
            end else begin
                s = stq.pop_front();
                if (s.at != cyc || int'(state_dbg) != s.st || drop_req != s.req) begin
                    fails++;
                    $display("FAIL state: got st=%0d req=%0b@%0d, expected st=%0d req=%0b@%0d",
                             state_dbg, drop_req, cyc, s.st, s.req, s.at);
                end
            end
            if (drop_req && !prev_req) check_ev("R");
            if (!drop_req && prev_req) check_ev("F");
            if (lock_pulse) check_ev("L");
            prev_req <= drop_req;
        end
        if (fin_req && !fin_done) begin
            tests++;
            if (evq.size() != 0) begin
                fails++;
                $display("FAIL ev_missing: got %0d outstanding, expected 0 (next %s@%0d)",
                         evq.size(), evq[0].kind, evq[0].at);
            end
            tests++;
            if (to_cnt != 0) begin
                fails++;
                $display("FAIL timeout: got %0d expired waits, expected 0", to_cnt);
            end
            fin_done <= 1;
        end
    end

    // ---------------- stimulus ----------------
    int tick_tmr = 0;
    int req_age = 0;
    int idle_tmr = 0;
    int done_cnt = 0;

    task automatic step();
        model_step();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic tick_gen(input int tick_max);
        if (tick_tmr == 0) begin
            tick_in = ~tick_in;
            tick_tmr = $urandom_range(tick_max, 0);
        end else begin
            tick_tmr--;
        end
    endtask

    task automatic run(input int ncyc, input int lvl, input bit sd, input int ack_dly,
                       input int land_pct, input int abort_pm, input int tick_max,
                       input int hold);
        level = LEVEL_W'(lvl);
        soft_drop = sd;
        for (int i = 0; i < ncyc; i++) begin
            tick_gen(tick_max);
            drop_ack = 1'b0;
            landed = 1'($urandom_range(1, 0));
            if (drop_req) begin
                req_age++;
                if (req_age >= ack_dly) begin
                    drop_ack = 1'b1;
                    landed = ($urandom_range(99, 0) < land_pct);
                end
            end else begin
                req_age = 0;
                if ($urandom_range(9, 0) == 0) drop_ack = 1'b1;
            end
            if (!piece_active) begin
                if (idle_tmr == 0) piece_active = 1'b1;
                else idle_tmr--;
            end else if (m_ph == M_DONE) begin
                done_cnt++;
                if (done_cnt > hold) begin
                    piece_active = 1'b0;
                    done_cnt = 0;
                    idle_tmr = $urandom_range(4, 0);
                end
            end else if ($urandom_range(999, 0) < abort_pm) begin
                piece_active = 1'b0;
                idle_tmr = $urandom_range(4, 0);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        mon_on = 1;
        step();
        step();
        rst = 1'b0;
        piece_active = 1'b1;
        step();
        step();

        // level 0, slow ack, never lands
        run(500, 0, 1'b0, 3, 0, 0, 2, 10);
        // clamp to floor, then mid level
        run(200, 15, 1'b0, 1, 0, 0, 2, 10);
        run(300, 5, 1'b0, 2, 0, 0, 2, 10);
        // always lands; hold the piece long after the lock pulse
        run(600, 0, 1'b0, 1, 100, 0, 1, 80);

        // abort with ack in the same cycle as piece loss
        piece_active = 1'b0;
        step();
        level = 4'd15;
        soft_drop = 1'b0;
        piece_active = 1'b1;
        drop_ack = 1'b0;
        for (int i = 0; i < 300 && !drop_req; i++) begin
            tick_gen(2);
            step();
        end
        if (!drop_req) to_cnt++;
        piece_active = 1'b0;
        drop_ack = 1'b1;
        landed = 1'($urandom_range(1, 0));
        step();
        drop_ack = 1'b0;
        step();
        step();

        // soft drop at level 0
        run(300, 0, 1'b1, 1, 0, 0, 2, 10);

        // randomised mixes
        for (int k = 0; k < 8; k++) begin
            run(400, int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                int'($urandom_range(5, 1)), int'($urandom_range(100, 0)), 3,
                int'($urandom_range(4, 0)), int'($urandom_range(30, 0)));
        end

        // reset in the middle of operation
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(300, 3, 1'b0, 2, 50, 2, 2, 5);

        @(negedge CLK_50M);
        #1;
        mon_on = 0;
        fin_req = 1;
        repeat (2) @(negedge CLK_50M);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
